shift_driver: RTL and testbench



---
 rtl/shift_pkg.sv | 13 +
 rtl/shift_tick.sv | 32 +++
 rtl/shift_driver.sv | 116 +++++++++++
 tb/tb_shift_driver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and default geometry for the LED shift-register transmitter.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int WIDTH_DEF   = 6;
    localparam int CLK_DIV_DEF = 2;

endpackage

// File: rtl/shift_tick.sv
// Half-period counter: tick is combinational off the count, high on the terminal cycle.
// No backpressure; clr restarts the count from zero, en freezes it.
module shift_tick
    import shift_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]   TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/shift_driver.sv
// Serialises a word MSB-first on sdata/sclk, then strobes latch; done 2*CLK_DIV*WIDTH+CLK_DIV cycles after accept.
// in_ready only in IDLE (including the done cycle); inputs are ignored while a frame is in flight.
module shift_driver
    import shift_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             done
);

    localparam int            BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] word, word_nxt;
    logic [BW-1:0]    bcnt, bcnt_nxt;
    logic             sclk_nxt, sdata_nxt, latch_nxt, done_nxt;
    logic             accept, tick, tick_en;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign tick_en  = (state != IDLE);

    // Same counter paces both sclk half-periods and the latch pulse width.
    shift_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (tick_en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        word_nxt  = word;
        bcnt_nxt  = bcnt;
        sclk_nxt  = sclk;
        sdata_nxt = sdata;
        latch_nxt = latch;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                sclk_nxt  = 1'b0;
                latch_nxt = 1'b0;
                if (accept) begin
                    word_nxt  = in_data;
                    sdata_nxt = in_data[WIDTH-1];
                    bcnt_nxt  = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sclk_nxt = ~sclk;
                    // Data only moves on the falling edge, keeping it stable around every rise.
                    if (sclk) begin
                        bcnt_nxt = bcnt + BW'(1);
                        if (bcnt == LAST_BIT) begin
                            state_nxt = LATCH;
                            latch_nxt = 1'b1;
                        end else begin
                            word_nxt  = word << 1;
                            sdata_nxt = word[WIDTH-2];
                        end
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    latch_nxt = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word  <= '0;
            bcnt  <= '0;
            sclk  <= 1'b0;
            sdata <= 1'b0;
            latch <= 1'b0;
            done  <= 1'b0;
        end else begin
            word  <= word_nxt;
            bcnt  <= bcnt_nxt;
            sclk  <= sclk_nxt;
            sdata <= sdata_nxt;
            latch <= latch_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_shift_driver.sv
// Scoreboarded bench: a shift-register model per instance is fed from sclk/sdata and checked at latch.
module tb_shift_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    // default instance (CLK_DIV=2, WIDTH=6)
    logic [5:0] din;
    logic       vld, rdy, sclk, sdata, latch, done;
    // CLK_DIV=1, WIDTH=6
    logic [5:0] din_a;
    logic       vld_a, rdy_a, sclk_a, sdata_a, latch_a, done_a;
    // CLK_DIV=3, WIDTH=8
    logic [7:0] din_b;
    logic       vld_b, rdy_b, sclk_b, sdata_b, latch_b, done_b;

    shift_driver u_dut (
        .clk(clk), .rst(rst), .in_data(din), .in_valid(vld), .in_ready(rdy),
        .sclk(sclk), .sdata(sdata), .latch(latch), .done(done)
    );

    shift_driver #(.WIDTH(6), .CLK_DIV(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_data(din_a), .in_valid(vld_a), .in_ready(rdy_a),
        .sclk(sclk_a), .sdata(sdata_a), .latch(latch_a), .done(done_a)
    );

    shift_driver #(.WIDTH(8), .CLK_DIV(3)) u_dut_b (
        .clk(clk), .rst(rst), .in_data(din_b), .in_valid(vld_b), .in_ready(rdy_b),
        .sclk(sclk_b), .sdata(sdata_b), .latch(latch_b), .done(done_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboards and model state.
    logic [5:0] exp_q[$];
    logic [5:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         acc_t[$];
    int         acc_ta[$];
    int         acc_tb[$];
    logic [5:0] sr = '0, sr_a = '0;
    logic [7:0] sr_b = '0;
    logic       sclk_q = 0, latch_q = 0, sclka_q = 0, latcha_q = 0, sclkb_q = 0, latchb_q = 0;
    int         n_rise = 0, n_acc = 0, n_done = 0, latch_len = 0, n_b2b = 0;
    int         n_done_a = 0, n_done_b = 0, n_exp = 0;

    initial forever begin
        @(negedge clk);
        // default instance
        if (vld && rdy && !rst) begin
            acc_t.push_back(cyc + 1);
            n_acc++;
            if (done) n_b2b++;
        end
        if (sclk && !sclk_q) begin
            sr = {sr[4:0], sdata};
            n_rise++;
        end
        if (latch && !latch_q) begin
            if (exp_q.size() == 0) check("latch_unexpected", 1, 0);
            else check("latched_word", sr, exp_q.pop_front());
            latch_len = 0;
        end
        if (latch) latch_len++;
        if (!latch && latch_q) check("latch_len", latch_len, 2);
        if (done) begin
            if (acc_t.size() == 0) check("done_unexpected", 1, 0);
            else check("latency", cyc - acc_t.pop_front(), 26);
            n_done++;
        end
        sclk_q  = sclk;
        latch_q = latch;
        // CLK_DIV=1 instance
        if (vld_a && rdy_a && !rst) acc_ta.push_back(cyc + 1);
        if (sclk_a && !sclka_q) sr_a = {sr_a[4:0], sdata_a};
        if (latch_a && !latcha_q) begin
            if (exp_a.size() == 0) check("latch_a_unexpected", 1, 0);
            else check("latched_word_a", sr_a, exp_a.pop_front());
        end
        if (done_a) begin
            if (acc_ta.size() == 0) check("done_a_unexpected", 1, 0);
            else check("latency_a", cyc - acc_ta.pop_front(), 13);
            n_done_a++;
        end
        sclka_q  = sclk_a;
        latcha_q = latch_a;
        // CLK_DIV=3, WIDTH=8 instance
        if (vld_b && rdy_b && !rst) acc_tb.push_back(cyc + 1);
        if (sclk_b && !sclkb_q) sr_b = {sr_b[6:0], sdata_b};
        if (latch_b && !latchb_q) begin
            if (exp_b.size() == 0) check("latch_b_unexpected", 1, 0);
            else check("latched_word_b", sr_b, exp_b.pop_front());
        end
        if (done_b) begin
            if (acc_tb.size() == 0) check("done_b_unexpected", 1, 0);
            else check("latency_b", cyc - acc_tb.pop_front(), 51);
            n_done_b++;
        end
        sclkb_q  = sclk_b;
        latchb_q = latch_b;
    end

    // Present a word on the default instance and return just after the accepting edge; vld stays high.
    task automatic send(input logic [5:0] w);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        vld = 1'b1;
        din = w;
        exp_q.push_back(w);
        n_exp++;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (n_done >= target) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("done_timeout", n_done, target);
    endtask

    int base;

    initial begin
        rst = 1'b1;
        vld = 0; din = '0; vld_a = 0; din_a = '0; vld_b = 0; din_b = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            vld = 1'($urandom); din = 6'($urandom);
            vld_a = 1'($urandom); din_a = 6'($urandom);
            vld_b = 1'($urandom); din_b = 8'($urandom);
            @(negedge clk);
            check("rst_ready", {rdy, rdy_a, rdy_b}, 3'b111);
            check("rst_outputs", {sclk, sdata, latch, done}, 4'b0000);
        end
        @(posedge clk);
        #1;
        vld = 0; vld_a = 0; vld_b = 0;
        rst = 1'b0;

        // Single frame.
        base = n_rise;
        send(6'b101101);
        vld = 1'b0;
        wait_done(1);
        check("sclk_rises", n_rise - base, 6);

        // Back-to-back: second word taken in the done cycle of the first.
        send(6'b111000);
        send(6'b000111);
        vld = 1'b0;
        wait_done(3);
        check("b2b_accept_in_done", n_b2b, 1);

        // Busy isolation.
        send(6'b010101);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            vld = ~vld;
            din = 6'b111111;
        end
        vld = 1'b0;
        wait_done(4);
        repeat (5) @(negedge clk);
        check("accept_count", n_acc, n_exp);

        // Asynchronous reset after the 3rd sclk rise.
        base = n_rise;
        send(6'b110011);
        vld = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_rise - base >= 3) break;
        end
        check("pre_rst_sclk", sclk, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {sclk, sdata, latch, done}, 4'b0000);
        check("async_rst_ready", rdy, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("aborted_no_done", n_done, 4);
        check("aborted_no_latch", exp_q.size(), 1);
        check("post_rst_ready", rdy, 1);
        exp_q.delete();
        acc_t.delete();
        send(6'b001100);
        vld = 1'b0;
        wait_done(5);

        // Parameter sweep, both instances in parallel.
        @(posedge clk);
        #1;
        vld_a = 1'b1; din_a = 6'b100110; exp_a.push_back(6'b100110);
        vld_b = 1'b1; din_b = 8'b10110010; exp_b.push_back(8'b10110010);
        @(posedge clk);
        #1;
        vld_a = 1'b0; vld_b = 1'b0;
        din_a = 6'b011001; din_b = 8'b01001101;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_done_b >= 1) break;
        end
        check("sweep_a_done", n_done_a, 1);
        check("sweep_b_done", n_done_b, 1);

        repeat (5) @(negedge clk);
        check("sb_empty", exp_q.size() + exp_a.size() + exp_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
